// File: rtl/fluxo_dados_rodadas_if.sv
// rtl/fluxo_dados_rodadas_if.sv - strobe/status bundle between the game control unit and the round datapath
interface fluxo_dados_rodadas_if #(
    parameter int W       = 4,
    parameter int N       = 4,
    parameter int TIMEOUT = 5000
);
    localparam int TW = $clog2(TIMEOUT);

    logic          zeraE;
    logic          contaE;
    logic          zeraL;
    logic          contaL;
    logic          zeraR;
    logic          registraR;
    logic          zeraT;
    logic          contaT;
    logic [W-1:0]  chaves;

    logic          jogada_igual;
    logic          endereco_igual_limite;
    logic          fimE;
    logic          fimL;
    logic          jogada_feita;
    logic          jogada_valida;
    logic          timeout;
    logic          db_tem_jogada;
    logic [N-1:0]  db_contagem;
    logic [N-1:0]  db_limite;
    logic [W-1:0]  db_memoria;
    logic [W-1:0]  db_jogada;
    logic [TW-1:0] db_timeout;

    modport master (
        output zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraT, contaT, chaves,
        input  jogada_igual, endereco_igual_limite, fimE, fimL, jogada_feita,
               jogada_valida, timeout, db_tem_jogada, db_contagem, db_limite,
               db_memoria, db_jogada, db_timeout
    );

    modport slave (
        input  zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraT, contaT, chaves,
        output jogada_igual, endereco_igual_limite, fimE, fimL, jogada_feita,
               jogada_valida, timeout, db_tem_jogada, db_contagem, db_limite,
               db_memoria, db_jogada, db_timeout
    );
endinterface

// File: rtl/fluxo_dados_rodadas.sv
// rtl/fluxo_dados_rodadas.sv - sequence-memory game datapath: address/limit counters, ROM, play register, edge detect, timeout
module fluxo_dados_rodadas #(
    parameter int W       = 4,
    parameter int N       = 4,
    parameter int TIMEOUT = 5000
) (
    input  logic                  clock,
    input  logic                  reset,
    fluxo_dados_rodadas_if.slave  bus
);
    localparam int DEPTH = 2 ** N;
    localparam int TW    = $clog2(TIMEOUT);
    localparam logic [N-1:0]  LAST = {N{1'b1}};
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    logic [N-1:0]  cnt_e;
    logic [N-1:0]  cnt_l;
    logic [W-1:0]  rom_q;
    logic [W-1:0]  jogada;
    logic          s1;
    logic          s2;
    logic [TW-1:0] cnt_t;
    logic          feita;
    logic [W-1:0]  rom [DEPTH];

    // Fixed pattern: word i lights switch (i mod W), cycling through the one-hot plays
    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom[i] = W'(1) << (i % W);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_e <= '0;
            cnt_l <= '0;
            rom_q <= '0;
        end else begin
            if (bus.zeraE)       cnt_e <= '0;
            else if (bus.contaE) cnt_e <= cnt_e + 1'b1;
            if (bus.zeraL)       cnt_l <= '0;
            else if (bus.contaL) cnt_l <= cnt_l + 1'b1;
            rom_q <= rom[cnt_e];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            jogada <= '0;
            s1     <= 1'b0;
            s2     <= 1'b0;
        end else if (bus.zeraR) begin
            jogada <= '0;
            s1     <= 1'b0;
            s2     <= 1'b0;
        end else begin
            if (bus.registraR) jogada <= bus.chaves;
            s1 <= |bus.chaves;
            s2 <= s1;
        end
    end

    assign feita = s1 & ~s2;

    // A fresh play restarts the wait just like an explicit clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                        cnt_t <= '0;
        else if (bus.zeraT || feita)       cnt_t <= '0;
        else if (bus.contaT && cnt_t < TMAX) cnt_t <= cnt_t + 1'b1;
    end

    assign bus.jogada_igual          = (rom_q == jogada);
    assign bus.endereco_igual_limite = (cnt_e == cnt_l);
    assign bus.fimE                  = (cnt_e == LAST);
    assign bus.fimL                  = (cnt_l == LAST);
    assign bus.jogada_feita          = feita;
    assign bus.jogada_valida         = ($countones(jogada) == 1);
    assign bus.timeout               = (cnt_t == TMAX);
    assign bus.db_tem_jogada         = |bus.chaves;
    assign bus.db_contagem           = cnt_e;
    assign bus.db_limite             = cnt_l;
    assign bus.db_memoria            = rom_q;
    assign bus.db_jogada             = jogada;
    assign bus.db_timeout            = cnt_t;
endmodule

// File: tb/tb_fluxo_dados_rodadas.sv
// tb/tb_fluxo_dados_rodadas.sv - self-checking bench for fluxo_dados_rodadas against a behavioural game model
module tb_fluxo_dados_rodadas;
    localparam int W       = 4;
    localparam int N       = 4;
    localparam int TIMEOUT = 8;
    localparam int DEPTH   = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fluxo_dados_rodadas_if #(.W(W), .N(N), .TIMEOUT(TIMEOUT)) bus ();

    fluxo_dados_rodadas #(.W(W), .N(N), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int         m_e, m_l, m_t;
    logic [3:0] m_jog, m_rom;
    bit         m_seen1, m_seen2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ones(input logic [3:0] v);
        int c = 0;
        for (int i = 0; i < 4; i++) if (v[i]) c++;
        return c;
    endfunction

    task automatic model_reset();
        m_e = 0; m_l = 0; m_t = 0; m_jog = '0; m_rom = '0; m_seen1 = 0; m_seen2 = 0;
    endtask

    task automatic check_all();
        chk("jogada_igual",   32'(bus.jogada_igual),          32'(m_rom == m_jog));
        chk("end_igual_lim",  32'(bus.endereco_igual_limite), 32'(m_e == m_l));
        chk("fimE",           32'(bus.fimE),                  32'(m_e == DEPTH - 1));
        chk("fimL",           32'(bus.fimL),                  32'(m_l == DEPTH - 1));
        chk("jogada_feita",   32'(bus.jogada_feita),          32'(m_seen1 && !m_seen2));
        chk("jogada_valida",  32'(bus.jogada_valida),         32'(ones(m_jog) == 1));
        chk("timeout",        32'(bus.timeout),               32'(m_t == TIMEOUT - 1));
        chk("db_tem_jogada",  32'(bus.db_tem_jogada),         32'(bus.chaves != 0));
        chk("db_contagem",    32'(bus.db_contagem),           32'(m_e));
        chk("db_limite",      32'(bus.db_limite),             32'(m_l));
        chk("db_memoria",     32'(bus.db_memoria),            32'(m_rom));
        chk("db_jogada",      32'(bus.db_jogada),             32'(m_jog));
        chk("db_timeout",     32'(bus.db_timeout),            32'(m_t));
    endtask

    task automatic idle();
        bus.zeraE = 0; bus.contaE = 0; bus.zeraL = 0; bus.contaL = 0;
        bus.zeraR = 0; bus.registraR = 0; bus.zeraT = 0; bus.contaT = 0;
    endtask

    // Advance one clock: next state follows the game rules applied to the inputs seen before the edge
    task automatic tick();
        int ne, nl, nt;
        logic [3:0] nj, nr;
        bit n1, n2, play;
        play = m_seen1 && !m_seen2;
        ne = bus.zeraE ? 0 : (bus.contaE ? (m_e + 1) % DEPTH : m_e);
        nl = bus.zeraL ? 0 : (bus.contaL ? (m_l + 1) % DEPTH : m_l);
        nr = 4'b0001 << (m_e % W);
        nj = bus.zeraR ? 4'b0000 : (bus.registraR ? bus.chaves : m_jog);
        n1 = bus.zeraR ? 0 : (bus.chaves != 0);
        n2 = bus.zeraR ? 0 : m_seen1;
        if (bus.zeraT || play)                     nt = 0;
        else if (bus.contaT && m_t < TIMEOUT - 1)  nt = m_t + 1;
        else                                       nt = m_t;
        @(posedge clock); #1;
        m_e = ne; m_l = nl; m_rom = nr; m_jog = nj; m_seen1 = n1; m_seen2 = n2; m_t = nt;
        check_all();
    endtask

    int pulses;

    initial begin
        idle();
        bus.chaves = '0;
        model_reset();
        #2;
        check_all();
        chk("rst_end_igual", 32'(bus.endereco_igual_limite), 32'd1);
        chk("rst_igual", 32'(bus.jogada_igual), 32'd1);
        @(negedge clock); reset = 1'b1;
        tick();
        chk("rom_word0", 32'(bus.db_memoria), 32'h1);

        // Address counter wrap and clear priority
        bus.contaE = 1;
        repeat (15) tick();
        chk("e_15", 32'(bus.db_contagem), 32'd15);
        chk("fimE_15", 32'(bus.fimE), 32'd1);
        tick();
        chk("e_wrap", 32'(bus.db_contagem), 32'd0);
        chk("fimE_wrap", 32'(bus.fimE), 32'd0);
        tick(); tick();
        bus.zeraE = 1;
        tick();
        chk("e_zera_prio", 32'(bus.db_contagem), 32'd0);

        // Address/limit match and play comparison
        idle(); bus.zeraL = 1; bus.zeraE = 1; tick();
        idle(); bus.contaE = 1; bus.contaL = 1;
        repeat (3) tick();
        idle(); tick();
        chk("e_eq_l", 32'(bus.endereco_igual_limite), 32'd1);
        chk("rom_word3", 32'(bus.db_memoria), 32'h8);
        bus.chaves = 4'b1000; bus.registraR = 1; tick();
        chk("igual_hit", 32'(bus.jogada_igual), 32'd1);
        bus.chaves = 4'b0100; tick();
        chk("igual_miss", 32'(bus.jogada_igual), 32'd0);
        chk("valida_1", 32'(bus.jogada_valida), 32'd1);
        bus.chaves = 4'b0110; tick();
        chk("valida_2", 32'(bus.jogada_valida), 32'd0);

        // Edge detector: two separate presses give two single-cycle pulses
        idle(); bus.chaves = 4'b0000; tick(); tick();
        pulses = 0;
        bus.chaves = 4'b0010;
        repeat (10) begin tick(); if (bus.jogada_feita) pulses++; end
        bus.chaves = 4'b0000; tick(); if (bus.jogada_feita) pulses++;
        bus.chaves = 4'b0010; tick(); if (bus.jogada_feita) pulses++;
        tick(); if (bus.jogada_feita) pulses++;
        chk("pulse_count", 32'(pulses), 32'd2);
        bus.chaves = 4'b0011;
        pulses = 0;
        repeat (4) begin tick(); if (bus.jogada_feita) pulses++; end
        chk("no_pulse_change", 32'(pulses), 32'd0);

        // Timeout saturation then cleared by a play
        bus.chaves = 4'b0000; tick(); tick();
        bus.zeraT = 1; tick();
        idle(); bus.contaT = 1;
        repeat (6) tick();
        chk("timeout_6", 32'(bus.timeout), 32'd0);
        tick();
        chk("timeout_7", 32'(bus.timeout), 32'd1);
        repeat (3) tick();
        chk("timeout_sat", 32'(bus.db_timeout), 32'd7);
        bus.chaves = 4'b0001; tick();
        chk("timeout_pulse", 32'(bus.jogada_feita), 32'd1);
        tick();
        chk("timeout_clr", 32'(bus.db_timeout), 32'd0);
        chk("timeout_clr_f", 32'(bus.timeout), 32'd0);

        // Randomised strobes and switches
        idle(); bus.chaves = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            bus.zeraE     = ($urandom_range(0, 15) == 0);
            bus.contaE    = $urandom_range(0, 1);
            bus.zeraL     = ($urandom_range(0, 15) == 0);
            bus.contaL    = $urandom_range(0, 1);
            bus.zeraR     = ($urandom_range(0, 11) == 0);
            bus.registraR = $urandom_range(0, 1);
            bus.zeraT     = ($urandom_range(0, 19) == 0);
            bus.contaT    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0)
                bus.chaves = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            tick();
        end

        // Asynchronous reset mid-count with timeout saturated
        idle(); bus.chaves = 4'b0000;
        bus.zeraE = 1; bus.zeraL = 1; bus.zeraT = 1; bus.zeraR = 1; tick();
        idle(); tick(); tick();
        bus.contaE = 1; bus.contaL = 1; bus.contaT = 1;
        repeat (3) tick();
        bus.contaL = 0;
        repeat (2) tick();
        bus.contaE = 0;
        repeat (4) tick();
        chk("pre_e5", 32'(bus.db_contagem), 32'd5);
        chk("pre_l3", 32'(bus.db_limite), 32'd3);
        chk("pre_sat", 32'(bus.timeout), 32'd1);
        #3 reset = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("async_e", 32'(bus.db_contagem), 32'd0);
        chk("async_to", 32'(bus.timeout), 32'd0);
        idle();
        @(negedge clock); reset = 1'b1;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
